uart_tx_feeder: RTL and testbench

//  Byte buffer and send sequencer directly upstream of uart_transmitter.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_fifo.sv | 80 ++++++++
 rtl/uart_tx_feeder.sv | 93 +++++++++
 tb/tb_uart_tx_feeder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit feeder and its FIFO.
package uart_pkg;

  localparam int DBITS_DEFAULT     = 8;
  localparam int ADDR_BITS_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_fifo.sv
// Circular byte FIFO with registered occupancy flags and a registered read port.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DBITS     = DBITS_DEFAULT,
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DBITS-1:0]     wr_data,
  input  logic                 rd_load,
  input  logic                 pop,
  output logic [DBITS-1:0]     rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   count
);

  localparam int                 DEPTH    = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);
  localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS:0]   CNT_FULL = (ADDR_BITS + 1)'(DEPTH);

  logic [DBITS-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   count_next;
  logic                 push;
  logic                 take;

  // Writes are gated by the registered full flag, so a write in a pop cycle
  // while full is still dropped.
  assign push = wr_en && !full;
  assign take = pop && !empty;

  always_comb begin
    count_next = count;
    case ({push, take})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (take) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_next;
      full  <= (count_next == CNT_FULL);
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_load) begin
      rd_data <= mem[rd_ptr];
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers system-side bytes and hands them one at a time to uart_transmitter,
// waiting for tx_done before releasing each FIFO entry.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DBITS     = DBITS_DEFAULT,
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) (
  input  logic                 clk_100MHz,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DBITS-1:0]     wr_data,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow,
  output logic                 tx_start,
  output logic [DBITS-1:0]     tx_data,
  input  logic                 tx_done,
  output logic                 busy
);

  state_t state;
  state_t state_next;
  logic   load;
  logic   pop;

  // The head entry is only popped once the transmitter reports completion,
  // so it stays counted for the whole frame.
  uart_fifo #(
    .DBITS     (DBITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_fifo (
    .clk     (clk_100MHz),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_load (load),
    .pop     (pop),
    .rd_data (tx_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    tx_start   = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        load       = 1'b1;
        state_next = START;
      end
      START: begin
        tx_start   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          pop        = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a queue-based reference and a
// transmitter stand-in that answers each tx_start with tx_done 10 cycles later.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;

  logic       clk_100MHz = 1'b0;
  logic       reset      = 1'b1;
  logic       wr_en      = 1'b0;
  logic [7:0] wr_data    = 8'h00;
  logic       tx_done    = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;

  uart_tx_feeder #(.DBITS(8), .ADDR_BITS(4)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .busy       (busy)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: bytes still owned by the feeder, sticky drop flag, and the
  // delay until the next expected start (-1 when none is scheduled).
  logic [7:0] mq[$];
  bit         m_ovf  = 1'b0;
  bit         m_wait = 1'b0;
  int         m_gap  = -1;

  logic [7:0] sent[$];
  bit         stall  = 1'b0;
  int         tx_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    int sz;
    bit pop;
    bit wr;
    if (reset) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_wait = 1'b0;
      m_gap  = -1;
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_overflow", overflow, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_busy", busy, 0);
      return;
    end
    sz = mq.size();
    check("count", count, sz);
    check("empty", empty, sz == 0);
    check("full", full, sz == DEPTH);
    check("overflow", overflow, m_ovf);
    check("busy", busy, m_wait || m_gap >= 0);
    check("tx_start", tx_start, m_gap == 0);
    if ((m_gap == 0 || m_wait) && sz > 0) check("tx_data", tx_data, mq[0]);
    if (tx_start) sent.push_back(tx_data);
    pop = m_wait && tx_done;
    wr  = wr_en && sz < DEPTH;
    if (wr_en && sz == DEPTH) m_ovf = 1'b1;
    if (m_gap == 0) begin
      m_gap  = -1;
      m_wait = 1'b1;
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (!m_wait && sz > 0) begin
      m_gap = 1;
    end
    if (pop) begin
      void'(mq.pop_front());
      m_wait = 1'b0;
    end
    if (wr) mq.push_back(wr_data);
  endtask

  // One clock: check/update at the falling edge, then play the transmitter
  // just after the rising edge. Returns at posedge+1.
  task automatic step();
    @(negedge clk_100MHz);
    compare_cycle();
    @(posedge clk_100MHz);
    #1;
    tx_done = 1'b0;
    if (reset) begin
      tx_cnt = 0;
    end else begin
      if (tx_cnt > 0 && !stall) begin
        tx_cnt--;
        if (tx_cnt == 0) tx_done = 1'b1;
      end
      if (tx_start) tx_cnt = 10;
    end
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (!busy && empty) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_idle: still busy after %0d cycles", max_cycles);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int base;
    bit found;
    logic [7:0] t2 [4];
    t2[0] = 8'h66; t2[1] = 8'h6C; t2[2] = 8'h61; t2[3] = 8'h67;

    // Test 1: single byte latency
    step();
    step();
    reset = 1'b0;
    check("t1_tx_data_after_reset", tx_data, 8'h00);
    check("t1_empty_after_reset", empty, 1);
    wr(8'h41);
    check("t1_no_start_c1", tx_start, 0);
    step();
    check("t1_no_start_c2", tx_start, 0);
    check("t1_busy_c2", busy, 1);
    step();
    check("t1_start_c3", tx_start, 1);
    check("t1_data_c3", tx_data, 8'h41);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (tx_done) found = 1'b1;
    end
    check("t1_done_seen", found, 1);
    check("t1_count_at_done", count, 1);
    step();
    check("t1_empty_after_done", empty, 1);

    // Test 2: four back-to-back writes
    base = sent.size();
    for (int i = 0; i < 4; i++) wr(t2[i]);
    wait_idle(200);
    check("t2_n_sent", sent.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (sent.size() > base + i) check("t2_order", sent[base+i], t2[i]);

    // Test 3: stalled transmitter, fill and overflow, then drain
    base  = sent.size();
    stall = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'h10 + 8'(i));
    check("t3_full", full, 1);
    check("t3_count16", count, 16);
    check("t3_no_ovf_yet", overflow, 0);
    wr(8'hAA);
    check("t3_ovf", overflow, 1);
    check("t3_count_held", count, 16);
    stall = 1'b0;
    wait_idle(400);
    check("t3_n_sent", sent.size() - base, 16);
    if (sent.size() >= base + 16) begin
      check("t3_first", sent[base], 8'h10);
      check("t3_last", sent[base+15], 8'h1F);
    end

    // Test 4: 40 paced bytes, pointers wrap twice
    pulse_reset();
    base = sent.size();
    for (int i = 0; i < 40; i++) begin
      wr(8'(i));
      repeat (11) step();
    end
    wait_idle(300);
    check("t4_n_sent", sent.size() - base, 40);
    for (int i = 0; i < 40; i++)
      if (sent.size() > base + i) check("t4_order", sent[base+i], i);
    check("t4_no_ovf", overflow, 0);

    // Test 5: reset during WAIT with five queued
    pulse_reset();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) wr(8'h30 + 8'(i));
    repeat (5) step();
    check("t5_busy_pre", busy, 1);
    check("t5_count_pre", count, 5);
    reset = 1'b1;
    #1;
    check("t5_tx_start_rst", tx_start, 0);
    check("t5_count_rst", count, 0);
    check("t5_busy_rst", busy, 0);
    base = sent.size();
    step();
    reset = 1'b0;
    stall = 1'b0;
    repeat (30) step();
    check("t5_no_start", sent.size(), base);
    wr(8'h5A);
    repeat (3) step();
    check("t5_restart_n", sent.size(), base + 1);
    if (sent.size() > base) check("t5_restart_data", sent[base], 8'h5A);
    wait_idle(100);

    // Test 6: write coincident with pop while full
    pulse_reset();
    base  = sent.size();
    stall = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i));
    check("t6_full", full, 1);
    stall = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (tx_done) begin
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        found   = 1'b1;
      end
    end
    check("t6_done_seen", found, 1);
    step();
    wr_en = 1'b0;
    check("t6_count15", count, 15);
    check("t6_ovf", overflow, 1);
    check("t6_not_full", full, 0);
    wr(8'hEF);
    check("t6_count16", count, 16);
    check("t6_full_again", full, 1);
    wait_idle(400);
    check("t6_n_sent", sent.size() - base, 17);
    if (sent.size() >= base + 17) begin
      check("t6_16th", sent[base+15], 8'h8F);
      check("t6_17th", sent[base+16], 8'hEF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
